// File: rtl/rptr_empty.sv
// Read-domain pointer and status generator for the async FIFO.
// Owns the binary/Gray read pointers and derives empty, almost-empty,
// fill count and sticky underflow from the synchronized Gray write pointer.
module rptr_empty #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AE_THRESH  = 1
) (
    input  logic                  i_rclk,
    input  logic                  i_rrst_n,
    input  logic                  i_rinc,
    input  logic [ADDR_WIDTH:0]   i_rq2_wptr,
    input  logic                  i_clr_underflow,
    output logic [ADDR_WIDTH-1:0] o_raddr,
    output logic [ADDR_WIDTH:0]   o_rptr,
    output logic                  o_rempty,
    output logic                  o_ralmost_empty,
    output logic [ADDR_WIDTH:0]   o_rcount,
    output logic                  o_runderflow
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] wbin;
    logic [PW-1:0] count_next;
    logic          accept;
    logic          empty_next;
    logic          ae_next;
    logic          underflow_next;

    // Next-state pointer and status computation from the post-edge read pointer.
    always_comb begin
        accept         = 1'b0;
        rbin_next      = rbin;
        rgray_next     = '0;
        wbin           = '0;
        count_next     = '0;
        empty_next     = 1'b1;
        ae_next        = 1'b1;
        underflow_next = o_runderflow;

        accept     = i_rinc & ~o_rempty;
        rbin_next  = rbin + PW'(accept);
        rgray_next = (rbin_next >> 1) ^ rbin_next;

        // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
        for (int i = 0; i < int'(PW); i++) begin
            wbin[i] = ^(i_rq2_wptr >> i);
        end

        count_next = wbin - rbin_next;
        empty_next = (rgray_next == i_rq2_wptr);
        ae_next    = (count_next <= PW'(AE_THRESH));

        // A read attempt while empty sets the flag and wins over a clear.
        if (i_rinc && o_rempty) begin
            underflow_next = 1'b1;
        end else if (i_clr_underflow) begin
            underflow_next = 1'b0;
        end
    end

    // Pointer and status registers.
    always_ff @(posedge i_rclk or negedge i_rrst_n) begin
        if (!i_rrst_n) begin
            rbin            <= '0;
            o_rptr          <= '0;
            o_rempty        <= 1'b1;
            o_ralmost_empty <= 1'b1;
            o_rcount        <= '0;
            o_runderflow    <= 1'b0;
        end else begin
            rbin            <= rbin_next;
            o_rptr          <= rgray_next;
            o_rempty        <= empty_next;
            o_ralmost_empty <= ae_next;
            o_rcount        <= count_next;
            o_runderflow    <= underflow_next;
        end
    end

    // Memory address is the low bits of the registered binary pointer.
    assign o_raddr = rbin[ADDR_WIDTH-1:0];

endmodule
